// File: rtl/buffer_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buffer_feeder_pkg
// Description : Shared FSM encoding and data-width default for the feeder
//               and the dual-clock word buffer bench.
// Revision    : 1.0
// ============================================================================
package buffer_feeder_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module      : buffer_feeder
// Description : Write-side burst producer; drives an incrementing word pattern
//               into the word buffer, pausing on buffer_full.
// Revision    : 1.0
// ============================================================================
module buffer_feeder
    import buffer_feeder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W  = 8,
    parameter int GAP    = 0
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] base,
    input  logic [LEN_W-1:0]  length,
    input  logic              buffer_full,
    output logic [DATA_W-1:0] data_1,
    output logic              data_1_en,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_sent
);

    localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

    feeder_state_e     state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    // State register
    always_ff @(posedge clk_1) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!buffer_full) begin
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (GAP > 0) begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; the strobe is combinational so backpressure acts immediately
    always_comb begin
        data_1_en  = (state_q == ST_SEND) && !buffer_full && !rst;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        data_1     = data_q;
        words_sent = words_q;
    end

    // Datapath next values
    always_comb begin
        data_d      = data_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        gap_d       = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (length != '0)) begin
                    data_d      = base;
                    remaining_d = length;
                    words_d     = '0;
                end
            end
            ST_SEND: begin
                if (!buffer_full) begin
                    data_d      = data_q + DATA_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    words_d     = words_q + LEN_W'(1);
                    gap_d       = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1) begin
        if (rst) begin
            data_q      <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            gap_q       <= '0;
        end else begin
            data_q      <= data_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            gap_q       <= gap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_feeder
// Description : Directed bench for buffer_feeder with GAP=0 and GAP=2 instances.
// Revision    : 1.0
// ============================================================================
module tb_buffer_feeder;

    logic        clk;
    logic        rst;
    logic        start0, start2;
    logic [15:0] base;
    logic [7:0]  length;
    logic        full;

    logic [15:0] data0, data2;
    logic        en0, en2, busy0, busy2, done0, done2;
    logic [7:0]  ws0, ws2;

    int checks = 0;
    int errors = 0;
    int words0 = 0;
    int words2 = 0;
    logic [15:0] q0[$];
    logic [15:0] q2[$];

    buffer_feeder #(.DATA_W(16), .LEN_W(8), .GAP(0)) dut0 (
        .clk_1(clk), .rst(rst), .start(start0), .base(base), .length(length),
        .buffer_full(full), .data_1(data0), .data_1_en(en0), .busy(busy0),
        .done(done0), .words_sent(ws0)
    );

    buffer_feeder #(.DATA_W(16), .LEN_W(8), .GAP(2)) dut2 (
        .clk_1(clk), .rst(rst), .start(start2), .base(base), .length(length),
        .buffer_full(full), .data_1(data2), .data_1_en(en2), .busy(busy2),
        .done(done2), .words_sent(ws2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every accepted word must match the next expected entry
    always @(negedge clk) begin
        if (en0) begin
            words0++;
            chk("dut0_word_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) chk("dut0_word", data0, q0.pop_front());
        end
        if (en2) begin
            words2++;
            chk("dut2_word_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) chk("dut2_word", data2, q2.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst0(input logic [15:0] b, input logic [7:0] l);
        for (int i = 0; i < int'(l); i++) q0.push_back(b + 16'(i));
        base = b; length = l; start0 = 1'b1;
        tick();
        start0 = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (done0) seen = 1'b1;
        end
        chk("dut0_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int cyc;
        logic seen2;
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic seen2;
        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; base = '0; length = '0; full = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", data0, 16'h0);
        chk("reset_en", en0, 1'b0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_done", done0, 1'b0);
        chk("reset_words", ws0, 8'd0);
        tick();

        // Reset mid-burst
        burst0(16'h0100, 8'd10);
        @(negedge clk);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_en_low", en0, 1'b0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_words", ws0, 8'd0);
        q0.delete();
        tick();

        // Back-to-back
        words0 = 0;
        burst0(16'h0010, 8'd4);
        wait_done0(cyc);
        chk("b2b_cycles", cyc, 5);
        chk("b2b_words_sent", ws0, 8'd4);
        chk("b2b_busy_in_done", busy0, 1'b1);
        tick();
        @(negedge clk);
        chk("b2b_busy_idle", busy0, 1'b0);
        chk("b2b_done_pulse", done0, 1'b0);
        chk("b2b_words_hold", ws0, 8'd4);
        chk("b2b_word_count", words0, 4);
        tick();

        // Backpressure
        words0 = 0;
        burst0(16'h0010, 8'd3);
        @(negedge clk);
        tick();
        full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_en_low", en0, 1'b0);
            chk("bp_data_hold", data0, 16'h0011);
            tick();
        end
        full = 1'b0;
        wait_done0(cyc);
        chk("bp_words_sent", ws0, 8'd3);
        chk("bp_word_count", words0, 3);
        chk("bp_sb_empty", q0.size(), 0);
        tick();

        // Wrap
        burst0(16'hFFFE, 8'd3);
        wait_done0(cyc);
        chk("wrap_words_sent", ws0, 8'd3);
        chk("wrap_sb_empty", q0.size(), 0);
        tick();

        // Zero-length start ignored
        base = 16'h0055; length = 8'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("zero_len_busy", busy0, 1'b0);
            chk("zero_len_done", done0, 1'b0);
            tick();
        end

        // Start while busy is ignored
        words0 = 0;
        burst0(16'h0200, 8'd5);
        tick();
        base = 16'h0999; length = 8'd7; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(cyc);
        chk("busy_start_words_sent", ws0, 8'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_start_no_second", busy0, 1'b0);
            tick();
        end
        chk("busy_start_word_count", words0, 5);
        chk("busy_start_sb_empty", q0.size(), 0);

        // GAP=2 instance
        words2 = 0;
        for (int i = 0; i < 3; i++) q2.push_back(16'h0300 + 16'(i));
        base = 16'h0300; length = 8'd3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        seen2 = 1'b0;
        for (int i = 0; i < 20 && !seen2; i++) begin
            @(negedge clk);
            cyc++;
            chk("gap_en_pattern", en2, 32'(cyc == 1 || cyc == 4 || cyc == 7));
            if (done2) seen2 = 1'b1;
        end
        chk("gap_done_seen", 32'(seen2), 32'd1);
        chk("gap_cycles", cyc, 8);
        chk("gap_words_sent", ws2, 8'd3);
        chk("gap_word_count", words2, 3);
        tick();
        @(negedge clk);
        chk("gap_busy_idle", busy2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
